// File: rtl/ysyx_regfile_mp.sv
// rtl/ysyx_regfile_mp.sv - multi-port integer register file with zero-clear sequence and busy scoreboard
module ysyx_regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int NWR     = 1,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_rf_ready,
    input  logic [NWR-1:0]        i_rf_wr_en,
    input  logic [NWR*AW-1:0]     i_waddr,
    input  logic [NWR*XLEN-1:0]   i_wdata,
    input  logic [NRD*AW-1:0]     i_raddr,
    output logic [NRD*XLEN-1:0]   o_rdata,
    input  logic                  i_sb_set_en,
    input  logic [AW-1:0]         i_sb_set_addr,
    output logic [NREG-1:0]       o_sb_busy
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_rf [NREG];
    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_busy_nxt;
    logic              w_ready;

    assign w_ready    = (r_state == ST_READY);
    assign o_rf_ready = w_ready;
    assign o_sb_busy  = r_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_cnt == AW'(NREG - 1)) begin
            w_state_nxt = ST_READY;
        end
    end

    // Array has no reset: the INIT walk zeroes it one entry per cycle instead.
    always_ff @(posedge i_clk) begin
        if (!w_ready) begin
            r_rf[r_cnt] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (i_rf_wr_en[i] && !(ZERO_R0 != 0 && i_waddr[i*AW +: AW] == '0)) begin
                    r_rf[i_waddr[i*AW +: AW]] <= i_wdata[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Set is applied after the write clears so a newly issued producer keeps the bit.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_ready) begin
            for (int i = 0; i < NWR; i++) begin
                if (i_rf_wr_en[i]) begin
                    w_busy_nxt[i_waddr[i*AW +: AW]] = 1'b0;
                end
            end
            if (i_sb_set_en) begin
                w_busy_nxt[i_sb_set_addr] = 1'b1;
            end
        end
        if (ZERO_R0 != 0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;

        assign w_ra = i_raddr[j*AW +: AW];

        always_comb begin
            w_rd = r_rf[w_ra];
            if (BYPASS != 0) begin
                for (int i = 0; i < NWR; i++) begin
                    if (i_rf_wr_en[i] && i_waddr[i*AW +: AW] == w_ra) begin
                        w_rd = i_wdata[i*XLEN +: XLEN];
                    end
                end
            end
            if (!w_ready || (ZERO_R0 != 0 && w_ra == '0)) begin
                w_rd = '0;
            end
        end

        assign o_rdata[j*XLEN +: XLEN] = w_rd;
    end

endmodule

// File: tb/tb_ysyx_regfile_mp.sv
// tb/tb_ysyx_regfile_mp.sv - self-checking bench for ysyx_regfile_mp (bypass and non-bypass instances)
module tb_ysyx_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic         clk;
    logic         rst_n;
    logic [1:0]   we;
    logic [9:0]   waddr;
    logic [63:0]  wdata;
    logic [9:0]   raddr;
    logic         se;
    logic [4:0]   sa;
    logic         a_ready, b_ready;
    logic [63:0]  a_rdata, b_rdata;
    logic [31:0]  a_busy, b_busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_rf [NREG];
    logic [31:0] m_busy;
    logic        m_ready;
    int          m_cnt;

    ysyx_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2), .ZERO_R0(1), .BYPASS(1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .o_rf_ready(a_ready),
        .i_rf_wr_en(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr(raddr), .o_rdata(a_rdata),
        .i_sb_set_en(se), .i_sb_set_addr(sa), .o_sb_busy(a_busy)
    );

    ysyx_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2), .ZERO_R0(1), .BYPASS(0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .o_rf_ready(b_ready),
        .i_rf_wr_en(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr(raddr), .o_rdata(b_rdata),
        .i_sb_set_en(se), .i_sb_set_addr(sa), .o_sb_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic        se;
        logic [4:0]  sa;
        logic [31:0] ea0, ea1, eb0, eb1;
        logic [31:0] ebusy;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic s, input logic [4:0] sadr);
        we    = w;
        waddr = {a1, a0};
        wdata = {d1, d0};
        raddr = {r1, r0};
        se    = s;
        sa    = sadr;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit byp);
        logic [31:0] v;
        if (!m_ready || addr == 5'd0) return 32'd0;
        v = m_rf[addr];
        if (byp) begin
            for (int i = 0; i < 2; i++) begin
                if (we[i] && waddr[i*AW +: AW] == addr) v = wdata[i*XLEN +: XLEN];
            end
        end
        return v;
    endfunction

    // Reference behaviour of one rising edge, applied with the inputs that were present before it.
    task automatic model_edge();
        logic [4:0] a;
        if (rst_n) begin
            if (m_ready) begin
                for (int i = 0; i < 2; i++) begin
                    if (we[i]) begin
                        a = waddr[i*AW +: AW];
                        if (a != 5'd0) m_rf[a] = wdata[i*XLEN +: XLEN];
                        m_busy[a] = 1'b0;
                    end
                end
                if (se) m_busy[sa] = 1'b1;
                m_busy[0] = 1'b0;
            end else begin
                m_cnt++;
                if (m_cnt == NREG) begin
                    m_ready = 1'b1;
                    for (int r = 0; r < NREG; r++) m_rf[r] = 32'd0;
                end
            end
        end
    endtask

    task automatic edge_update();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_cnt   = 0;
        m_busy  = 32'd0;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!a_ready && n < 100) begin
            if (n == 4) drive(2'b01, 5'd5, 5'd0, 32'hCAFE0005, 32'd0, 5'd5, 5'd0, 1'b1, 5'd5);
            else        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0);
            #2;
            if (n == 4) check({nm, " init_rdata_forced0"}, a_rdata[31:0], 64'd0);
            edge_update();
            n++;
        end
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
        check({nm, " ready_latency"}, 64'(n), 64'd32);
        check({nm, " b_ready"}, {63'd0, b_ready}, 64'd1);
        check({nm, " busy_after_init"}, {32'd0, a_busy}, 64'd0);
    endtask

    initial begin
        tbl[0] = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 5'd5, 5'd5, 1'b0, 5'd0,
                   32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0};
        tbl[1] = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0,
                   32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'd0, 32'd0};
        tbl[2] = '{2'b01, 5'd0, 5'd0, 32'h12345678, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0,
                   32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[3] = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd7, 1'b0, 5'd0,
                   32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[4] = '{2'b11, 5'd7, 5'd7, 32'h1111, 32'h2222, 5'd7, 5'd5, 1'b0, 5'd0,
                   32'h2222, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'd0};
        tbl[5] = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd7, 5'd7, 1'b0, 5'd0,
                   32'h2222, 32'h2222, 32'h2222, 32'h2222, 32'd0};
        tbl[6] = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd7, 1'b1, 5'd9,
                   32'd0, 32'h2222, 32'd0, 32'h2222, 32'h0000_0200};
        tbl[7] = '{2'b10, 5'd0, 5'd9, 32'd0, 32'h99, 5'd9, 5'd9, 1'b0, 5'd0,
                   32'h99, 32'h99, 32'd0, 32'd0, 32'd0};
        tbl[8] = '{2'b01, 5'd9, 5'd0, 32'hAA, 32'd0, 5'd9, 5'd7, 1'b1, 5'd9,
                   32'hAA, 32'h2222, 32'h99, 32'h2222, 32'h0000_0200};
        tbl[9] = '{2'b01, 5'd3, 5'd0, 32'hA5A5, 32'd0, 5'd3, 5'd9, 1'b1, 5'd3,
                   32'hA5A5, 32'hAA, 32'd0, 32'hAA, 32'h0000_0208};

        rst_n = 1'b0;
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_ready", {62'd0, a_ready, b_ready}, 64'd0);
        check("reset_busy", {a_busy, b_busy}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready("clear");

        for (int r = 0; r < NREG; r++) begin
            drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'(r), 5'(r), 1'b0, 5'd0);
            #2;
            check($sformatf("clear_a_r%0d", r), a_rdata[31:0], 64'd0);
            check($sformatf("clear_b_r%0d", r), b_rdata[63:32], 64'd0);
            edge_update();
        end

        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].we, tbl[k].wa0, tbl[k].wa1, tbl[k].wd0, tbl[k].wd1,
                  tbl[k].ra0, tbl[k].ra1, tbl[k].se, tbl[k].sa);
            #2;
            check($sformatf("vec%0d a_rd0", k), a_rdata[31:0],  {32'd0, tbl[k].ea0});
            check($sformatf("vec%0d a_rd1", k), a_rdata[63:32], {32'd0, tbl[k].ea1});
            check($sformatf("vec%0d b_rd0", k), b_rdata[31:0],  {32'd0, tbl[k].eb0});
            check($sformatf("vec%0d b_rd1", k), b_rdata[63:32], {32'd0, tbl[k].eb1});
            edge_update();
            check($sformatf("vec%0d a_busy", k), {32'd0, a_busy}, {32'd0, tbl[k].ebusy});
            check($sformatf("vec%0d b_busy", k), {32'd0, b_busy}, {32'd0, tbl[k].ebusy});
        end

        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd0, 1'b0, 5'd0);
        #2;
        check("pre_reset_r3", b_rdata[31:0], 64'hA5A5);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midreset_busy", {a_busy, b_busy}, 64'd0);
        check("midreset_ready", {62'd0, a_ready, b_ready}, 64'd0);
        check("midreset_rdata", a_rdata[31:0], 64'd0);
        edge_update();
        edge_update();
        rst_n = 1'b1;
        wait_ready("rerun");
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3, 1'b0, 5'd0);
        #2;
        check("after_reset_a_r3", a_rdata[31:0], 64'd0);
        check("after_reset_b_r3", b_rdata[63:32], 64'd0);
        edge_update();

        for (int c = 0; c < 400; c++) begin
            drive(2'($urandom), 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
                  $urandom, $urandom, 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 11)));
            #2;
            check($sformatf("rnd%0d a_rd0", c), a_rdata[31:0],  {32'd0, exp_read(raddr[4:0], 1'b1)});
            check($sformatf("rnd%0d a_rd1", c), a_rdata[63:32], {32'd0, exp_read(raddr[9:5], 1'b1)});
            check($sformatf("rnd%0d b_rd0", c), b_rdata[31:0],  {32'd0, exp_read(raddr[4:0], 1'b0)});
            check($sformatf("rnd%0d b_rd1", c), b_rdata[63:32], {32'd0, exp_read(raddr[9:5], 1'b0)});
            edge_update();
            check($sformatf("rnd%0d a_busy", c), {32'd0, a_busy}, {32'd0, m_busy});
            check($sformatf("rnd%0d b_busy", c), {32'd0, b_busy}, {32'd0, m_busy});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_regfile_mp.md
Name: ysyx_regfile_mp

Overview:
- Parametrised multi-port integer register file for the ysyx core; successor to the single-write, two-read register file.
- Adds configurable read/write port counts, an optional hardwired-zero r0, optional write-to-read bypass, and a post-reset zero-clear sequence.
- Adds a per-register busy scoreboard for the issue stage.
- Sits between the decode/issue stage (reads, scoreboard set) and the writeback stage (writes, scoreboard clear).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers; power of two, 2 or more. AW = clog2(NREG).
- NRD, 2, number of read ports.
- NWR, 1, number of write ports; 1 to 4.
- ZERO_R0, 1, when 1, register 0 reads as zero and ignores writes and scoreboard sets.
- BYPASS, 1, when 1, a read of a register being written in the same cycle returns the new data.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rf_ready  out  1  high once the clear sequence has finished.
- rf_wr_en  in  NWR  per-port write enable.
- waddr  in  NWR*AW  write addresses; port i occupies bits [i*AW +: AW].
- wdata  in  NWR*XLEN  write data; port i occupies bits [i*XLEN +: XLEN].
- raddr  in  NRD*AW  read addresses, packed the same way.
- rdata  out  NRD*XLEN  read data; combinational.
- sb_set_en  in  1  mark a register busy (issue of a producer).
- sb_set_addr  in  AW  register to mark busy.
- sb_busy  out  NREG  per-register busy bits.

Behaviour:
- Reset (rst_n low, async):
  - state goes to INIT; clear counter = 0; rf_ready = 0; sb_busy = all zero.
  - Array contents are undefined until the clear sequence completes.
- INIT state:
  - Each cycle, rf[cnt] <= 0 and cnt increments.
  - When cnt = NREG-1 is written, the next state is READY; rf_ready rises the cycle after the last clear, i.e. NREG cycles after rst_n deasserts.
  - rf_wr_en and sb_set_en are ignored; rdata is forced to 0.
- READY state: normal operation; stays in READY until the next reset. Reset asserted mid-INIT or in READY restarts the sequence from cnt = 0.
- Writes:
  - On the rising edge, each port with rf_wr_en[i] high writes wdata[i] to rf[waddr[i]].
  - If two ports target the same address, the highest-index port wins.
  - With ZERO_R0 = 1, writes to address 0 are dropped.
- Reads:
  - rdata[j] = rf[raddr[j]], combinational, zero-cycle latency.
  - With ZERO_R0 = 1 and raddr[j] = 0, rdata[j] = 0 regardless of the bypass.
  - With BYPASS = 1, if any enabled write port matches raddr[j] in the same cycle, rdata[j] = wdata of the highest-index matching port.
  - With BYPASS = 0, the new value is visible the cycle after the write.
- Scoreboard:
  - The edge after sb_set_en sets sb_busy[sb_set_addr].
  - An enabled write to address a clears sb_busy[a] on the same edge.
  - Set and write to the same address on the same edge: set wins, and the busy bit remains 1 (a new producer has been issued).
  - With ZERO_R0 = 1, sb_busy[0] is constantly 0.
  - No scoreboard updates occur in INIT.
- Out-of-range addresses cannot occur, because NREG is a power of two.

Test Plan:
- Clear sequence: NREG = 32; release rst_n, then poll rf_ready. rf_ready goes 1 exactly 32 cycles after release; every register then reads 0. A write in cycle 5 of INIT is lost.
- Basic write then read: write 0xDEADBEEF to r5. With BYPASS = 0, r5 reads 0 in the write cycle and 0xDEADBEEF the next cycle. With BYPASS = 1, r5 reads 0xDEADBEEF in the write cycle.
- Hardwired zero: write 0x12345678 to r0 with sb_set_addr = 0. r0 reads 0 in the same cycle and the next cycle; sb_busy[0] = 0.
- Write collision: NWR = 2; port0 writes 0x1111 and port1 writes 0x2222, both to r7. r7 reads 0x2222 afterwards; the same-cycle bypass also returns 0x2222.
- Scoreboard: set r9 -> sb_busy[9] = 1. Write r9 -> sb_busy[9] = 0. Set and write r9 on the same edge -> sb_busy[9] stays 1.
- Reset mid-operation: assert rst_n low while r3 = 0xA5A5 and sb_busy[3] = 1. sb_busy clears immediately and rf_ready drops; after release, r3 reads 0 once rf_ready = 1.
